distortion_ctrl: RTL and testbench
==================================

Name: distortion_ctrl

Overview:
- Sequencer for the stereo distortion datapath. It accepts one left/right sample pair per audio frame from the codec interface and time-multiplexes a single gain-multiply, serial-divide and clip pipeline across the left channel, then the right channel.
- Gain and clip settings are latched per frame. The block emits a clipped stereo pair with a one-cycle valid pulse and flags frames dropped because the pipeline was busy.

Parameters:
- CLIP_LEVEL, 24576, positive hard-clip magnitude used when clipEn=1 (must be ≤ 32767).
- DIV_CYCLES, 23, serial divider iterations; equals the magnitude width of the product.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sampleValid  in  1  one-cycle pulse; leftSampleIn/rightSampleIn are valid
- leftSampleIn  in  16  signed left sample
- rightSampleIn  in  16  signed right sample
- gainNum  in  7  unsigned gain numerator, 0-127
- gainDen  in  7  unsigned gain denominator, 0-127; 0 = bypass gain
- clipEn  in  1  1 = clip to ±CLIP_LEVEL; 0 = saturate to 16-bit range
- clearOverrun  in  1  clears the overrun flag
- leftSampleOut  out  16  signed processed left sample
- rightSampleOut  out  16  signed processed right sample
- sampleOutValid  out  1  one-cycle pulse; outputs updated
- busy  out  1  high whenever state ≠ IDLE
- overrun  out  1  sticky; a sampleValid arrived while busy

Behaviour:
- Reset: state=IDLE; leftSampleOut=0, rightSampleOut=0, sampleOutValid=0, busy=0, overrun=0. Reset mid-frame aborts the frame with no valid pulse.
- States: IDLE, MUL_L, DIV_L, CLIP_L, MUL_R, DIV_R, CLIP_R, DONE.
- IDLE: sampleValid=1 captures both samples plus gainNum, gainDen and clipEn into frame registers, then moves to MUL_L. Input changes after capture have no effect on the frame in flight.
- MUL (1 cycle): prod = sample × gainNum as a 23-bit signed value. Divider loads |prod| and gainDen and starts.
- DIV (DIV_CYCLES cycles): restoring shift-subtract over unsigned magnitudes. The quotient sign is restored after the final iteration, truncating toward zero. If gainDen=0, the result is the captured sample unchanged (bypass), with identical latency.
- CLIP (1 cycle):
  - clipEn=1: result > CLIP_LEVEL → +CLIP_LEVEL; result < −CLIP_LEVEL → −CLIP_LEVEL.
  - clipEn=0: saturate to [−32768, 32767].
  - Result is stored in the channel's holding register.
- Sequence: CLIP_L → MUL_R → ... → CLIP_R → DONE.
- DONE (1 cycle): both outputs update simultaneously, sampleOutValid=1, next state IDLE. Outputs hold their values until the next DONE.
- Latency: if capture happens in cycle T, sampleOutValid is high in cycle T+2·(DIV_CYCLES+2)+1 = T+51 at defaults.
- Overrun: sampleValid while busy (including the DONE cycle) discards the sample and sets overrun=1.
  - clearOverrun=1 clears overrun next cycle.
  - If set and clear occur in the same cycle, set wins.
- gainNum=0 → output 0 (with gainDen≠0).
- Edge case: −32768 × 127 / 1 gives magnitude 4161536, which fits in 23 bits.

Decomposition:
- distortion_pkg holds:
  - state enum type
  - SAMPLE_W=16, GAIN_W=7, PROD_W=23
  - default CLIP_LEVEL
  - a function for the clip/saturate rule, shared with the bench model
- One sub-module, gain_divider: unsigned 23-bit ÷ 7-bit restoring divider with start/done, fixed DIV_CYCLES latency, and quotient output.

Test Plan:
- L=1000, R=−1000, gainNum=4, gainDen=1, clipEn=0 → L=4000, R=−4000, sampleOutValid exactly 51 cycles after capture, busy high for cycles T+1..T+51.
- L=10000, R=−10000, 8/1:
  - clipEn=0 → 32767 / −32768.
  - clipEn=1 → 24576 / −24576.
- L=−7, R=7, 1/2 → −3 / 3 (truncation toward zero). Separately, L=32767, 0/5 → 0.
- gainDen=0, gainNum=99, L=12345, R=−32768 → 12345 / −32768, same latency.
- Second sampleValid at T+20 → ignored, overrun=1, outputs reflect the first frame only. Then clearOverrun together with a new sampleValid in an idle cycle → overrun=0 and the frame is accepted.
- Reset asserted at T+30 → no sampleOutValid, outputs=0, busy=0. A new frame right after reset completes normally with 51-cycle latency.

Source files
------------

// File: rtl/distortion_pkg.sv
// distortion_pkg: shared types and constants for the stereo distortion sequencer.
//   state_t          - sequencer states
//   SAMPLE_W/GAIN_W/PROD_W - datapath widths
//   DEF_CLIP_LEVEL   - default hard-clip magnitude
//   DEF_DIV_CYCLES   - default divider iteration count (= PROD_W)
//   clip_sample()    - clip (clip_en=1) or 16-bit saturate (clip_en=0) rule
package distortion_pkg;

    localparam int unsigned SAMPLE_W       = 16;
    localparam int unsigned GAIN_W         = 7;
    localparam int unsigned PROD_W         = 23;
    localparam int          DEF_CLIP_LEVEL = 24576;
    localparam int unsigned DEF_DIV_CYCLES = 23;

    typedef enum logic [2:0] {
        IDLE,
        MUL_L,
        DIV_L,
        CLIP_L,
        MUL_R,
        DIV_R,
        CLIP_R,
        DONE
    } state_t;

    // Returns the limited value as a full int; callers narrow it to SAMPLE_W.
    function automatic int clip_sample(input int v, input logic clip_en, input int level);
        int hi;
        int lo;
        if (clip_en) begin
            hi = level;
            lo = -level;
        end else begin
            hi = 32767;
            lo = -32768;
        end
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/gain_divider.sv
// gain_divider: unsigned PROD_W / GAIN_W restoring shift-subtract divider.
//   clk, reset  - clock, synchronous active-high reset
//   start       - load dividend/divisor and begin DIV_CYCLES iterations
//   dividend    - unsigned magnitude to divide
//   divisor     - unsigned divisor (0 yields all-ones; caller handles bypass)
//   done        - high during the final iteration; quotient valid next cycle
//   quotient    - unsigned quotient, held until the next start
module gain_divider
    import distortion_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = DEF_DIV_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [PROD_W-1:0] dividend,
    input  logic [GAIN_W-1:0] divisor,
    output logic              done,
    output logic [PROD_W-1:0] quotient
);

    localparam int unsigned CNT_W = $clog2(DIV_CYCLES + 1);

    logic [GAIN_W-1:0] rem;
    logic [GAIN_W-1:0] den;
    logic [PROD_W-1:0] quo;
    logic [CNT_W-1:0]  cnt;
    logic [GAIN_W:0]   partial;
    logic              fits;

    // The quotient register doubles as the dividend shift register: each
    // iteration shifts the next dividend bit out of the top and the new
    // quotient bit in at the bottom.
    always_comb begin
        partial = {rem, quo[PROD_W-1]};
        fits    = (partial >= {1'b0, den});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem <= '0;
            den <= '0;
            quo <= '0;
            cnt <= '0;
        end else if (start) begin
            rem <= '0;
            den <= divisor;
            quo <= dividend;
            cnt <= CNT_W'(DIV_CYCLES);
        end else if (cnt != '0) begin
            rem <= fits ? GAIN_W'(partial - {1'b0, den}) : partial[GAIN_W-1:0];
            quo <= {quo[PROD_W-2:0], fits};
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign done     = (cnt == CNT_W'(1));
    assign quotient = quo;

endmodule

// File: rtl/distortion_ctrl.sv
// distortion_ctrl: per-frame sequencer sharing one gain-multiply, divide and
// clip pipeline between the left and right channels.
//   clk, reset        - clock, synchronous active-high reset
//   sampleValid       - one-cycle pulse, left/right samples valid
//   leftSampleIn      - signed left sample
//   rightSampleIn     - signed right sample
//   gainNum, gainDen  - unsigned gain ratio; gainDen=0 bypasses the gain
//   clipEn            - 1: clip to +/-CLIP_LEVEL, 0: saturate to 16 bits
//   clearOverrun      - clears the sticky overrun flag
//   leftSampleOut     - processed left sample (held until next frame)
//   rightSampleOut    - processed right sample (held until next frame)
//   sampleOutValid    - one-cycle pulse when outputs update
//   busy              - frame in progress
//   overrun           - sticky: a sample arrived while busy and was dropped
module distortion_ctrl
    import distortion_pkg::*;
#(
    parameter int          CLIP_LEVEL = DEF_CLIP_LEVEL,
    parameter int unsigned DIV_CYCLES = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sampleValid,
    input  logic [15:0] leftSampleIn,
    input  logic [15:0] rightSampleIn,
    input  logic [6:0]  gainNum,
    input  logic [6:0]  gainDen,
    input  logic        clipEn,
    input  logic        clearOverrun,
    output logic [15:0] leftSampleOut,
    output logic [15:0] rightSampleOut,
    output logic        sampleOutValid,
    output logic        busy,
    output logic        overrun
);

    state_t state, next_state;

    logic [SAMPLE_W-1:0] frame_left;
    logic [SAMPLE_W-1:0] frame_right;
    logic [GAIN_W-1:0]   frame_num;
    logic [GAIN_W-1:0]   frame_den;
    logic                frame_clip;
    logic [SAMPLE_W-1:0] left_hold;
    logic [SAMPLE_W-1:0] left_out;
    logic [SAMPLE_W-1:0] right_out;
    logic                overrun_q;

    logic [SAMPLE_W-1:0] cur;
    logic [SAMPLE_W-1:0] cur_mag;
    logic [PROD_W-1:0]   prod_mag;
    logic                div_start;
    logic                div_done;
    logic [PROD_W-1:0]   div_quo;
    int                  div_result;
    logic [SAMPLE_W-1:0] clipped;

    gain_divider #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (prod_mag),
        .divisor  (frame_den),
        .done     (div_done),
        .quotient (div_quo)
    );

    // Datapath: the product is formed as |sample| * num so the divider only
    // sees magnitudes; the sign is reapplied after division, which makes the
    // quotient truncate toward zero. |-32768| = 32768 still fits 16 unsigned bits.
    always_comb begin
        cur = (state == MUL_L || state == DIV_L || state == CLIP_L) ? frame_left : frame_right;
        cur_mag   = cur[SAMPLE_W-1] ? (~cur + 16'd1) : cur;
        prod_mag  = PROD_W'(cur_mag) * PROD_W'(frame_num);
        div_start = (state == MUL_L) || (state == MUL_R);
        if (frame_den == '0)
            div_result = int'($signed(cur));
        else if (cur[SAMPLE_W-1])
            div_result = -int'(div_quo);
        else
            div_result = int'(div_quo);
        clipped = SAMPLE_W'(clip_sample(div_result, frame_clip, CLIP_LEVEL));
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (sampleValid) next_state = MUL_L;
            MUL_L:   next_state = DIV_L;
            DIV_L:   if (div_done) next_state = CLIP_L;
            CLIP_L:  next_state = MUL_R;
            MUL_R:   next_state = DIV_R;
            DIV_R:   if (div_done) next_state = CLIP_R;
            CLIP_R:  next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            frame_left  <= '0;
            frame_right <= '0;
            frame_num   <= '0;
            frame_den   <= '0;
            frame_clip  <= 1'b0;
            left_hold   <= '0;
            left_out    <= '0;
            right_out   <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE && sampleValid) begin
                frame_left  <= leftSampleIn;
                frame_right <= rightSampleIn;
                frame_num   <= gainNum;
                frame_den   <= gainDen;
                frame_clip  <= clipEn;
            end
            // Set has priority over clear.
            if (state != IDLE && sampleValid)
                overrun_q <= 1'b1;
            else if (clearOverrun)
                overrun_q <= 1'b0;
            if (state == CLIP_L)
                left_hold <= clipped;
            // Both outputs are loaded on the CLIP_R->DONE edge so they are
            // already valid during the DONE cycle alongside sampleOutValid.
            if (state == CLIP_R) begin
                left_out  <= left_hold;
                right_out <= clipped;
            end
        end
    end

    assign leftSampleOut  = left_out;
    assign rightSampleOut = right_out;
    assign sampleOutValid = (state == DONE);
    assign busy           = (state != IDLE);
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_distortion_ctrl.sv
module tb_distortion_ctrl;

    localparam int CLIP = 24576;
    localparam int LAT  = 51;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sampleValid = 1'b0;
    logic [15:0] leftSampleIn = '0;
    logic [15:0] rightSampleIn = '0;
    logic [6:0]  gainNum = '0;
    logic [6:0]  gainDen = '0;
    logic        clipEn = 1'b0;
    logic        clearOverrun = 1'b0;
    logic [15:0] leftSampleOut;
    logic [15:0] rightSampleOut;
    logic        sampleOutValid;
    logic        busy;
    logic        overrun;

    int tests = 0;
    int fails = 0;

    distortion_ctrl #(
        .CLIP_LEVEL (CLIP),
        .DIV_CYCLES (23)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .sampleValid    (sampleValid),
        .leftSampleIn   (leftSampleIn),
        .rightSampleIn  (rightSampleIn),
        .gainNum        (gainNum),
        .gainDen        (gainDen),
        .clipEn         (clipEn),
        .clearOverrun   (clearOverrun),
        .leftSampleOut  (leftSampleOut),
        .rightSampleOut (rightSampleOut),
        .sampleOutValid (sampleOutValid),
        .busy           (busy),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: gain as an exact integer ratio truncated toward zero, then limited.
    function automatic int model(input int s, input int num, input int den, input bit ce);
        int v;
        int hi;
        int lo;
        v  = (den == 0) ? s : (s * num) / den;
        hi = ce ? CLIP : 32767;
        lo = ce ? -CLIP : -32768;
        if (v > hi) v = hi;
        if (v < lo) v = lo;
        return v;
    endfunction

    task automatic scramble_inputs();
        leftSampleIn  = 16'($urandom);
        rightSampleIn = 16'($urandom);
        gainNum       = 7'($urandom);
        gainDen       = 7'($urandom);
        clipEn        = 1'($urandom);
    endtask

    // Sends one frame and follows it to completion. inj_at>0 fires an extra
    // sampleValid in that cycle after capture; rst_at>0 pulses reset there.
    task automatic run_frame(input string tag, input int l, input int r, input int num,
                             input int den, input bit ce, input int inj_at,
                             input int rst_at, input bit clr);
        int  exp_l;
        int  exp_r;
        int  n;
        int  seen;
        bit  busy_ok;
        exp_l = model(l, num, den, ce);
        exp_r = model(r, num, den, ce);
        leftSampleIn  = 16'(l);
        rightSampleIn = 16'(r);
        gainNum       = 7'(num);
        gainDen       = 7'(den);
        clipEn        = ce;
        sampleValid   = 1'b1;
        clearOverrun  = clr;
        tick();
        sampleValid  = 1'b0;
        clearOverrun = 1'b0;
        if (clr) chk({tag, ".ovr_clr"}, 32'(overrun), 0);
        n = 1;
        busy_ok = 1'b1;
        if (rst_at > 0) begin
            while (n < rst_at) begin
                scramble_inputs();
                tick();
                n++;
            end
            reset = 1'b1;
            tick();
            reset = 1'b0;
            chk({tag, ".rst_valid"}, 32'(sampleOutValid), 0);
            chk({tag, ".rst_busy"}, 32'(busy), 0);
            chk({tag, ".rst_left"}, $signed(leftSampleOut), 0);
            chk({tag, ".rst_right"}, $signed(rightSampleOut), 0);
            seen = 0;
            for (int i = 0; i < 70; i++) begin
                if (sampleOutValid) seen++;
                tick();
            end
            chk({tag, ".rst_no_pulse"}, seen, 0);
            return;
        end
        while (sampleOutValid !== 1'b1 && n < 120) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            scramble_inputs();
            sampleValid = (n == inj_at);
            tick();
            sampleValid = 1'b0;
            n++;
        end
        chk({tag, ".latency"}, n, LAT);
        chk({tag, ".busy_span"}, 32'(busy_ok && busy === 1'b1), 1);
        chk({tag, ".left"}, $signed(leftSampleOut), exp_l);
        chk({tag, ".right"}, $signed(rightSampleOut), exp_r);
        if (inj_at > 0) chk({tag, ".overrun"}, 32'(overrun), 1);
        tick();
        chk({tag, ".pulse_end"}, 32'(sampleOutValid), 0);
        chk({tag, ".idle"}, 32'(busy), 0);
        tick();
        chk({tag, ".hold_l"}, $signed(leftSampleOut), exp_l);
        chk({tag, ".hold_r"}, $signed(rightSampleOut), exp_r);
    endtask

    initial begin
        tick();
        tick();
        chk("reset.left", $signed(leftSampleOut), 0);
        chk("reset.right", $signed(rightSampleOut), 0);
        chk("reset.valid", 32'(sampleOutValid), 0);
        chk("reset.busy", 32'(busy), 0);
        chk("reset.overrun", 32'(overrun), 0);
        reset = 1'b0;
        tick();

        run_frame("gain4", 1000, -1000, 4, 1, 1'b0, 0, 0, 1'b0);
        run_frame("sat", 10000, -10000, 8, 1, 1'b0, 0, 0, 1'b0);
        run_frame("clip", 10000, -10000, 8, 1, 1'b1, 0, 0, 1'b0);
        run_frame("trunc", -7, 7, 1, 2, 1'b0, 0, 0, 1'b0);
        run_frame("zero", 32767, -5, 0, 5, 1'b0, 0, 0, 1'b0);
        run_frame("bypass", 12345, -32768, 99, 0, 1'b0, 0, 0, 1'b0);
        run_frame("maxmag", -32768, 32767, 127, 1, 1'b1, 0, 0, 1'b0);
        run_frame("maxdiv", -32768, 32767, 127, 127, 1'b0, 0, 0, 1'b0);
        chk("pre_ovr", 32'(overrun), 0);
        run_frame("ovr", 2000, -3000, 3, 2, 1'b0, 20, 0, 1'b0);
        run_frame("ovrclr", -1234, 4321, 5, 3, 1'b1, 0, 0, 1'b1);
        run_frame("midrst", 500, 600, 2, 1, 1'b0, 0, 30, 1'b0);
        run_frame("postrst", 500, 600, 2, 1, 1'b0, 0, 0, 1'b0);

        for (int k = 0; k < 16; k++) begin
            int l;
            int r;
            int num;
            int den;
            l   = int'($signed(16'($urandom)));
            r   = int'($signed(16'($urandom)));
            num = int'($urandom_range(0, 127));
            den = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 127));
            run_frame("rand", l, r, num, den, 1'($urandom), 0, 0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
